psram_cmd_sequencer: RTL and testbench

- Sits between the UART RX/TX byte interfaces and the PSRAM controller in top.
- Assembles the host command byte stream into one PSRAM request and issues it over a valid/ready handshake.
- Waits for the controller response and returns read data to the host as two TX bytes.
- Resynchronises on inter-byte timeout and flags malformed or dropped traffic.

---
 rtl/psram_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_psram_cmd_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/psram_cmd_sequencer.sv
// UART byte stream to PSRAM request sequencer with read-data return over TX.
// Define PSRAM_SEQ_WRACK_EN to send an ASCII 'W' after every completed write.
module psram_cmd_sequencer #(
  parameter int TIMEOUT_CYC = 20000,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_req_valid,
  input  logic              i_req_ready,
  output logic              o_req_we,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic [DATA_W-1:0] o_req_wdata,
  input  logic              i_rsp_valid,
  input  logic [DATA_W-1:0] i_rsp_rdata,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_timeout,
  output logic              o_err_sticky
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  // Counter value seen on the cycle before it would reach TIMEOUT_CYC-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 2);

  typedef enum logic [3:0] {
    IDLE, ADDR0, ADDR1, ADDR2, DATA0, DATA1, ISSUE, WAIT_RSP, TX_LO, TX_HI
`ifdef PSRAM_SEQ_WRACK_EN
    , TX_ACK
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       rdata_hi;
  logic             collect;
  logic             drop_rx;

  assign collect = state inside {ADDR0, ADDR1, ADDR2, DATA0, DATA1};
  assign drop_rx = i_rx_valid && !(collect || state == IDLE);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rdata_hi     <= '0;
      o_req_valid  <= 1'b0;
      o_req_we     <= 1'b0;
      o_req_addr   <= '0;
      o_req_wdata  <= '0;
      o_tx_data    <= '0;
      o_tx_valid   <= 1'b0;
      o_timeout    <= 1'b0;
      o_err_sticky <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      if (drop_rx) o_err_sticky <= 1'b1;
      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == 8'h00 || i_rx_data == 8'h01) begin
              o_req_we <= i_rx_data[0];
              cnt      <= '0;
              state    <= ADDR0;
            end else begin
              o_err_sticky <= 1'b1;
            end
          end
        end
        ADDR0, ADDR1, ADDR2, DATA0, DATA1: begin
          // An arriving byte beats a simultaneous timeout expiry.
          if (i_rx_valid) begin
            cnt <= '0;
            case (state)
              ADDR0: begin o_req_addr[7:0]   <= i_rx_data; state <= ADDR1; end
              ADDR1: begin o_req_addr[15:8]  <= i_rx_data; state <= ADDR2; end
              ADDR2: begin
                o_req_addr[23:16] <= i_rx_data;
                if (o_req_we) begin
                  state <= DATA0;
                end else begin
                  o_req_valid <= 1'b1;
                  state       <= ISSUE;
                end
              end
              DATA0: begin o_req_wdata[7:0] <= i_rx_data; state <= DATA1; end
              DATA1: begin
                o_req_wdata[15:8] <= i_rx_data;
                o_req_valid       <= 1'b1;
                state             <= ISSUE;
              end
              default: state <= IDLE;
            endcase
          end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            o_timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ISSUE: begin
          if (i_req_ready) begin
            o_req_valid <= 1'b0;
            state       <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (i_rsp_valid) begin
            if (o_req_we) begin
`ifdef PSRAM_SEQ_WRACK_EN
              o_tx_data  <= 8'h57;
              o_tx_valid <= 1'b1;
              state      <= TX_ACK;
`else
              state <= IDLE;
`endif
            end else begin
              o_tx_data  <= i_rsp_rdata[7:0];
              rdata_hi   <= i_rsp_rdata[15:8];
              o_tx_valid <= 1'b1;
              state      <= TX_LO;
            end
          end
        end
        TX_LO: begin
          if (i_tx_ready) begin
            o_tx_data <= rdata_hi;
            state     <= TX_HI;
          end
        end
        TX_HI: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= IDLE;
          end
        end
`ifdef PSRAM_SEQ_WRACK_EN
        TX_ACK: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_cmd_sequencer.sv
// Randomized and directed bench for psram_cmd_sequencer against a command-level model.
module tb_psram_cmd_sequencer;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_req_valid, i_req_ready, o_req_we;
  logic [23:0] o_req_addr;
  logic [15:0] o_req_wdata;
  logic        i_rsp_valid;
  logic [15:0] i_rsp_rdata;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid, i_tx_ready;
  logic        o_busy, o_timeout, o_err_sticky;
  logic [53:0] outs;

  int n_vec = 0;
  int n_err = 0;
  int n_to  = 0;
  logic [40:0] req_q[$];
  logic [7:0]  tx_q[$];
  logic        pv_q = 1'b0, tv_q = 1'b0;
  logic [40:0] pf_q;
  logic [7:0]  td_q;

  always #5 clk = ~clk;

  psram_cmd_sequencer #(.TIMEOUT_CYC(TO), .ADDR_W(24), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_we(o_req_we),
    .o_req_addr(o_req_addr), .o_req_wdata(o_req_wdata),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_err_sticky(o_err_sticky)
  );

  assign outs = {o_req_valid, o_req_we, o_req_addr, o_req_wdata, o_tx_valid, o_tx_data,
                 o_busy, o_timeout, o_err_sticky};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b; i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  // Handshake log and hold-stability checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (pv_q) chk("req_hold", {o_req_valid, o_req_we, o_req_addr, o_req_wdata}, {1'b1, pf_q});
    if (tv_q) chk("tx_hold", {o_tx_valid, o_tx_data}, {1'b1, td_q});
    pv_q <= !rst && o_req_valid && !i_req_ready;
    pf_q <= {o_req_we, o_req_addr, o_req_wdata};
    tv_q <= !rst && o_tx_valid && !i_tx_ready;
    td_q <= o_tx_data;
    if (!rst && o_req_valid && i_req_ready) req_q.push_back({o_req_we, o_req_addr, o_req_wdata});
    if (!rst && o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
    if (o_timeout) n_to <= n_to + 1;
  end

  // One full command: byte stream, request handshake, response, TX drain.
  task automatic do_cmd(input bit we, input logic [23:0] a, input logic [15:0] wd,
                        input logic [15:0] rd, input int gap, input int stall,
                        input bit hold_tx, input bit poke);
    logic [7:0]  b[$];
    logic [7:0]  exp_tx[$];
    logic [40:0] r;
    int          to0;
    to0 = n_to;
    b.push_back({7'b0, we});
    b.push_back(a[7:0]); b.push_back(a[15:8]); b.push_back(a[23:16]);
    if (we) begin b.push_back(wd[7:0]); b.push_back(wd[15:8]); end
    foreach (b[i]) begin
      if (i > 0) tick(gap < 0 ? int'($urandom_range(0, 3)) : gap);
      send_byte(b[i]);
    end
    chk("req_lat", o_req_valid, 1);
    i_req_ready = 1'b0;
    tick(stall);
    chk("req_still", o_req_valid, 1);
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    chk("req_drop", o_req_valid, 0);
    chk("req_cnt", req_q.size(), 1);
    if (req_q.size() > 0) begin
      r = req_q.pop_front();
      chk("req_we", r[40], we);
      chk("req_addr", r[39:16], a);
      if (we) chk("req_wdata", r[15:0], wd);
    end
    req_q.delete();
    tick(int'($urandom_range(0, 3)));
    if (poke) send_byte(8'h00);
    chk("busy_wait", o_busy, 1);
    i_rsp_valid = 1'b1; i_rsp_rdata = rd;
    tick();
    i_rsp_valid = 1'b0; i_rsp_rdata = 16'($urandom);
    if (!we) begin exp_tx.push_back(rd[7:0]); exp_tx.push_back(rd[15:8]); end
`ifdef PSRAM_SEQ_WRACK_EN
    else exp_tx.push_back(8'h57);
`endif
    if (hold_tx && exp_tx.size() > 0)
      repeat (5) begin
        chk("tx_hold_lo", {o_tx_valid, o_tx_data}, {1'b1, exp_tx[0]});
        tick();
      end
    for (int t = 0; t < 200 && o_busy; t++) begin
      i_tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    i_tx_ready = 1'b0;
    chk("idle_end", {o_busy, o_tx_valid}, 0);
    chk("tx_cnt", tx_q.size(), exp_tx.size());
    while (tx_q.size() > 0 && exp_tx.size() > 0)
      chk("tx_byte", tx_q.pop_front(), exp_tx.pop_front());
    tx_q.delete();
    chk("no_timeout", n_to, to0);
  endtask

  initial begin
    int to0;
    i_rx_data = '0; i_rx_valid = 1'b0; i_req_ready = 1'b0;
    i_rsp_valid = 1'b0; i_rsp_rdata = '0; i_tx_ready = 1'b0;
    tick(3);
    chk("rst_outs", outs, 0);
    rst = 1'b0;
    tick();

    do_cmd(1'b1, 24'h040302, 16'h0708, 16'h0000, 0, 0, 1'b0, 1'b0);
    do_cmd(1'b0, 24'h040302, 16'h0000, 16'h0708, 0, 0, 1'b1, 1'b0);
    do_cmd(1'b1, 24'($urandom), 16'($urandom), 16'h0, 0, 10, 1'b0, 1'b0);
    // Byte landing on the expiry cycle must be accepted.
    do_cmd(1'b1, 24'($urandom), 16'($urandom), 16'h0, TO - 2, 1, 1'b0, 1'b0);

    send_byte(8'h01);
    send_byte(8'h02);
    to0 = n_to;
    tick(TO - 2);
    chk("to_early", {o_timeout, o_busy}, 2'b01);
    chk("to_none", n_to, to0);
    tick();
    chk("to_pulse", {o_timeout, o_busy, o_err_sticky}, 3'b100);
    tick();
    chk("to_clear", o_timeout, 0);
    chk("to_cnt", n_to - to0, 1);
    do_cmd(1'b0, 24'h040302, 16'h0, 16'h0708, 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_rsp_valid = 1'b1; i_rsp_rdata = 16'($urandom);
        tick();
        i_rsp_valid = 1'b0;
      end
      do_cmd(1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom), 16'($urandom),
             -1, int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end
    chk("err_clean", o_err_sticky, 0);

    do_cmd(1'b0, 24'($urandom), 16'h0, 16'hBEEF, -1, 1, 1'b0, 1'b1);
    chk("err_drop", {o_err_sticky, o_busy}, 2'b10);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("err_rst", o_err_sticky, 0);
    send_byte(8'h55);
    chk("bad_op", {o_err_sticky, o_busy}, 2'b10);
    do_cmd(1'b0, 24'($urandom), 16'h0, 16'($urandom), -1, 2, 1'b0, 1'b0);

    rst = 1'b1; tick(); rst = 1'b0;
    send_byte(8'h00); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'hC3);
    i_req_ready = 1'b1; tick(); i_req_ready = 1'b0;
    chk("mid_wait", {o_busy, o_req_valid}, 2'b10);
    req_q.delete();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid", outs, 0);
    i_rsp_valid = 1'b1; i_rsp_rdata = 16'h1234; i_tx_ready = 1'b1;
    tick();
    i_rsp_valid = 1'b0;
    tick(2);
    i_tx_ready = 1'b0;
    chk("rsp_ignored", {o_busy, o_tx_valid}, 0);
    chk("rsp_no_tx", tx_q.size(), 0);
    do_cmd(1'b0, 24'h00ABCD, 16'h0, 16'h55AA, -1, 3, 1'b0, 1'b0);
    do_cmd(1'b1, 24'hFFFFFF, 16'hFFFF, 16'h0, -1, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
